ahb_seg_shifter: RTL
====================

// Module: ahb_seg_shifter
// PURPOSE
//  AHB-Lite slave on the mipsfpga_ahb bus. Drives the Sword board 7-segment serial shift chain (seg_clk/seg_pen/seg_do).
//  Software writes a 64-bit segment frame as two words; the block serialises it MSB-first, then pulses the latch enable.
//  Sits downstream of the m14k core's AHB master, beside the existing RAM/GPIO slaves; selected by the AHB address decoder.
// PARAMETERS
//  CLK_DIV     2   HCLK cycles per seg_clk half-period (>=1)
//  PEN_CYCLES  4   HCLK cycles seg_pen held high after the last bit (>=1)
//  FRAME_BITS  64  bits shifted per frame (fixed 64; parameter exists only for the bench)
// PORTS
//  HCLK       in   1   bus clock; only clock
//  HRESETn    in   1   asynchronous active-low reset
//  HSEL       in   1   slave select from the address decoder
//  HADDR      in   4   byte address within slave: 0x0 DATA_LO, 0x4 DATA_HI, 0x8 STATUS
//  HTRANS     in   2   AHB transfer type; bit1=1 means a valid transfer
//  HWRITE     in   1   1 = write
//  HSIZE      in   3   transfer size; word only, others treated as word
//  HREADY     in   1   bus-level ready; address phase accepted only when 1
//  HWDATA     in   32  write data (data phase)
//  HRDATA     out  32  read data (data phase)
//  HREADYOUT  out  1   0 = stall current data phase
//  HRESP      out  1   tied 0 (OKAY)
//  seg_clk    out  1   shift clock to the segment chain
//  seg_pen    out  1   latch/parallel enable
//  seg_do     out  1   serial data
// BEHAVIOUR
//  Reset: HRDATA=0, HREADYOUT=1, seg_clk=0, seg_pen=0, seg_do=0, stage_lo/hi=0, shadow=0, frame_cnt=0, FSM=IDLE.
//  Reset mid-frame aborts the frame immediately; no seg_pen pulse is produced.
//  Address phase: when HSEL & HTRANS[1] & HREADY, latch HADDR[3:2] and HWRITE. The access completes in the following data phase.
//  Write 0x0: stage_lo<=HWDATA, zero wait states.
//  Write 0x4, FSM==IDLE: stage_hi<=HWDATA, shadow<={HWDATA,stage_lo}, go to SHIFT; zero wait states.
//  Write 0x4, FSM!=IDLE: HREADYOUT=0 until FSM returns to IDLE, then commit as above in that cycle (HREADYOUT=1).
//  Write 0x8: ignored.
//  Read: 0x0->stage_lo; 0x4->stage_hi; 0x8->{frame_cnt[15:0],15'b0,busy}. Reads have zero wait states; HRDATA is registered and valid in the data phase.
//  FSM states and transitions:
//   IDLE  -> SHIFT on a committed DATA_HI write.
//   SHIFT: bit index i counts 63..0.
//    - seg_do=shadow[i] is set while seg_clk=0.
//    - seg_clk toggles every CLK_DIV cycles; the chain samples on the rising edge.
//    - After the falling edge following bit 0 -> LATCH.
//   LATCH: seg_pen=1 for PEN_CYCLES cycles, then seg_pen=0, frame_cnt+=1 (wraps at 16 bits) -> IDLE.
//  busy = (FSM!=IDLE).
//  Frame length = 64*2*CLK_DIV + PEN_CYCLES HCLK cycles (260 at defaults).
//  Commit and LATCH exit in the same cycle: the stalled write commits in the cycle after IDLE is entered. No frame is lost or overlapped.
//  A write to 0x0 during SHIFT affects only stage_lo, never the frame in flight.
// CONFIGURATION
//  SEG_HEX_DECODE_EN defined:
//   - Adds register 0x8 write = HEX mode.
//   - HWDATA holds 8 nibbles; each nibble is decoded to a 7-seg pattern (active-low, dp off).
//   - The 8 decoded bytes are packed into shadow (nibble7 -> shadow[63:56]) and start a frame with the same stall rules as 0x4.
//   - STATUS read is unchanged.
//  SEG_HEX_DECODE_EN undefined: writes to 0x8 are ignored; no decoder logic is present.
// STRUCTURE
//  Shared package/header (seg_pkg.vh):
//   - register offsets SEG_DATA_LO/HI/STATUS
//   - FSM state encodings IDLE/SHIFT/LATCH
//   - HTRANS_NONSEQ constant
//   - 16-entry hex->segment table
//  Sub-module seg_hex_decoder (combinational, 4->8), instantiated 8x only under SEG_HEX_DECODE_EN.
//  Top-level handles the AHB slave logic, FSM, divider and shift register.
// TESTING
//  1 Reset: assert HRESETn=0 mid-SHIFT -> all outputs reach reset values at once; STATUS reads 0 after release.
//  2 Write 0x0=0x89ABCDEF, 0x4=0x01234567 -> 64 rising seg_clk edges sample 0x0123456789ABCDEF MSB-first;
//    seg_pen high 4 cycles; total 260 cycles; STATUS=0x0001_0000.
//  3 Write 0x4 twice back-to-back -> second data phase HREADYOUT=0 for the remainder of the first frame;
//    second frame starts without a gap; frame_cnt=2.
//  4 Write 0x0=0xFFFFFFFF during SHIFT -> in-flight frame unchanged; readback 0x0=0xFFFFFFFF.
//  5 Read 0x8 during SHIFT -> bit0=1, zero wait states; HSEL=0 or HTRANS=IDLE transfers cause no state change.
//  6 (SEG_HEX_DECODE_EN) write 0x8=0x00000008 -> last shifted byte = hex table[8]; other bytes = table[0].

Source files
------------

// File: rtl/ahb_seg_shifter_pkg.sv
// Shared constants, FSM encoding and hex->7-segment table for ahb_seg_shifter.
package ahb_seg_shifter_pkg;

  // Register word offsets (HADDR[3:2])
  localparam logic [1:0] SegDataLo = 2'd0;
  localparam logic [1:0] SegDataHi = 2'd1;
  localparam logic [1:0] SegStatus = 2'd2;

  localparam logic [1:0] HtransNonseq = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } seg_state_e;

  // Active-low segments {dp,g,f,e,d,c,b,a}, dp off
  function automatic logic [7:0] seg_hex_lut(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ahb_seg_shifter_hex_decoder.sv
// Combinational nibble -> 7-segment byte decoder; only built with SEG_HEX_DECODE_EN.
`ifdef SEG_HEX_DECODE_EN
module ahb_seg_shifter_hex_decoder
  import ahb_seg_shifter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] segments
);

  assign segments = seg_hex_lut(nibble);

endmodule
`endif

// File: rtl/ahb_seg_shifter.sv
// AHB-Lite slave serialising a 64-bit frame onto the segment shift chain.
// Optional HEX write mode at offset 0x8 is enabled by defining SEG_HEX_DECODE_EN.
module ahb_seg_shifter
  import ahb_seg_shifter_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PEN_CYCLES = 4,
  parameter int unsigned FRAME_BITS = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        seg_clk,
  output logic        seg_pen,
  output logic        seg_do
);

  localparam int unsigned IdxW = $clog2(FRAME_BITS);
  localparam int unsigned DivW = $clog2(CLK_DIV + 1);
  localparam int unsigned PenW = $clog2(PEN_CYCLES + 1);

  seg_state_e      state_q, state_d;
  logic            dp_valid_q, dp_write_q;
  logic [1:0]      dp_addr_q;
  logic [31:0]     stage_lo_q, stage_lo_d, stage_hi_q, stage_hi_d;
  logic [63:0]     shadow_q, shadow_d, new_shadow;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [IdxW-1:0] bit_idx_q, bit_idx_d, next_idx;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [PenW-1:0] pen_cnt_q, pen_cnt_d;
  logic            seg_clk_q, seg_clk_d, seg_pen_q, seg_pen_d, seg_do_q, seg_do_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            addr_accept, dp_wr, wr_lo, wr_start_hi, wr_start_hex, start_req, commit, busy;
  logic            unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[1:0]};

  assign addr_accept  = HSEL & ((HTRANS & HtransNonseq) == HtransNonseq) & HREADY;
  assign dp_wr        = dp_valid_q & dp_write_q;
  assign wr_lo        = dp_wr & (dp_addr_q == SegDataLo);
  assign wr_start_hi  = dp_wr & (dp_addr_q == SegDataHi);
  assign busy         = (state_q != StIdle);
  assign start_req    = wr_start_hi | wr_start_hex;
  assign commit       = start_req & ~busy;
  // A frame-start write stalls until the previous frame has fully latched
  assign HREADYOUT    = ~(start_req & busy);
  assign HRESP        = 1'b0;
  assign HRDATA       = rdata_q;
  assign seg_clk      = seg_clk_q;
  assign seg_pen      = seg_pen_q;
  assign seg_do       = seg_do_q;

`ifdef SEG_HEX_DECODE_EN
  logic [63:0] hex_frame;

  assign wr_start_hex = dp_wr & (dp_addr_q == SegStatus);

  for (genvar n = 0; n < 8; n++) begin : g_hex
    ahb_seg_shifter_hex_decoder u_dec (
      .nibble   (HWDATA[4*n +: 4]),
      .segments (hex_frame[8*n +: 8])
    );
  end

  assign new_shadow = wr_start_hex ? hex_frame : {HWDATA, stage_lo_q};
`else
  assign wr_start_hex = 1'b0;
  assign new_shadow   = {HWDATA, stage_lo_q};
`endif

  assign next_idx = bit_idx_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    div_cnt_d   = div_cnt_q;
    pen_cnt_d   = pen_cnt_q;
    seg_clk_d   = seg_clk_q;
    seg_pen_d   = seg_pen_q;
    seg_do_d    = seg_do_q;
    shadow_d    = shadow_q;
    frame_cnt_d = frame_cnt_q;
    stage_lo_d  = wr_lo ? HWDATA : stage_lo_q;
    stage_hi_d  = (commit & wr_start_hi) ? HWDATA : stage_hi_q;

    unique case (state_q)
      StIdle: begin
        if (commit) begin
          state_d   = StShift;
          shadow_d  = new_shadow;
          bit_idx_d = IdxW'(FRAME_BITS - 1);
          div_cnt_d = '0;
          seg_clk_d = 1'b0;
          seg_do_d  = new_shadow[FRAME_BITS-1];
        end
      end
      StShift: begin
        if (div_cnt_q == DivW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          seg_clk_d = ~seg_clk_q;
          // Falling edge: advance to the next bit, or latch after bit 0
          if (seg_clk_q) begin
            if (bit_idx_q == '0) begin
              state_d   = StLatch;
              seg_pen_d = 1'b1;
              pen_cnt_d = '0;
            end else begin
              bit_idx_d = next_idx;
              seg_do_d  = shadow_q[next_idx];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StLatch: begin
        if (pen_cnt_q == PenW'(PEN_CYCLES - 1)) begin
          seg_pen_d   = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = StIdle;
        end else begin
          pen_cnt_d = pen_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data is captured at the address phase; bypass a write landing in the same cycle
  always_comb begin
    rdata_d = rdata_q;
    if (addr_accept && !HWRITE) begin
      unique case (HADDR[3:2])
        SegDataLo: rdata_d = wr_lo ? HWDATA : stage_lo_q;
        SegDataHi: rdata_d = (commit & wr_start_hi) ? HWDATA : stage_hi_q;
        SegStatus: rdata_d = {frame_cnt_q, 15'b0, busy};
        default:   rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= 2'd0;
      stage_lo_q  <= '0;
      stage_hi_q  <= '0;
      shadow_q    <= '0;
      frame_cnt_q <= '0;
      bit_idx_q   <= '0;
      div_cnt_q   <= '0;
      pen_cnt_q   <= '0;
      seg_clk_q   <= 1'b0;
      seg_pen_q   <= 1'b0;
      seg_do_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (HREADY) begin
        dp_valid_q <= addr_accept;
        dp_write_q <= HWRITE;
        dp_addr_q  <= HADDR[3:2];
      end
      state_q     <= state_d;
      stage_lo_q  <= stage_lo_d;
      stage_hi_q  <= stage_hi_d;
      shadow_q    <= shadow_d;
      frame_cnt_q <= frame_cnt_d;
      bit_idx_q   <= bit_idx_d;
      div_cnt_q   <= div_cnt_d;
      pen_cnt_q   <= pen_cnt_d;
      seg_clk_q   <= seg_clk_d;
      seg_pen_q   <= seg_pen_d;
      seg_do_q    <= seg_do_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
